// File: rtl/rv32_mem_pkg.sv
// Shared RV32 data-memory definitions: FUNCT3 access-size codes, controller states, size decode.
package rv32_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_t;

  // Unused FUNCT3 codes (011/110/111) fall back to a full word access.
  function automatic size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/dmem_busywait_ctrl_if.sv
// Word-wide backing-memory bus: req held until a 1-cycle ack; rdata valid with ack.
interface dmem_busywait_ctrl_if;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [3:0]  MEM_BE;
  logic [31:0] MEM_WDATA;
  logic [31:0] MEM_RDATA;
  logic        MEM_ACK;

  modport master (
    output MEM_REQ, MEM_WE, MEM_ADDR, MEM_BE, MEM_WDATA,
    input  MEM_RDATA, MEM_ACK
  );

  modport slave (
    input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_BE, MEM_WDATA,
    output MEM_RDATA, MEM_ACK
  );
endinterface

// File: rtl/dmem_load_align.sv
// Combinational load lane select with sign/zero extension by FUNCT3.
module dmem_load_align
  import rv32_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{lane, 3'b000} +: 8];
    half_sel = rdata[{lane[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h000000, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0000, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_busywait_ctrl.sv
// MEM-stage data-memory controller: one req/ack transaction per load/store, BUSYWAIT stalls the
// pipeline until it completes; store lane steering here, load extraction in dmem_load_align.
module dmem_busywait_ctrl
  import rv32_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        MEM_READ,
  input  logic                        MEM_WRITE,
  input  logic [2:0]                  FUNCT3,
  input  logic [31:0]                 ADDRESS,
  input  logic [31:0]                 WRITE_DATA,
  output logic [31:0]                 READ_DATA,
  output logic                        BUSYWAIT,
  output logic                        MISALIGNED,
  output logic                        BUS_ERROR,
  dmem_busywait_ctrl_if.master        mem
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [15:0] cnt;

  logic        req;
  logic        misaligned;
  size_t       sz;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] load_data;

  always_comb begin
    req        = MEM_READ | MEM_WRITE;
    sz         = f3_size(FUNCT3);
    misaligned = ((sz == SZ_H) && ADDRESS[0]) || ((sz == SZ_W) && (ADDRESS[1:0] != 2'b00));
    be_n       = 4'b1111;
    wdata_n    = 32'h0;
    if (MEM_WRITE) begin
      case (sz)
        SZ_B: begin
          be_n    = 4'b0001 << ADDRESS[1:0];
          wdata_n = {4{WRITE_DATA[7:0]}};
        end
        SZ_H: begin
          be_n    = ADDRESS[1] ? 4'b1100 : 4'b0011;
          wdata_n = {2{WRITE_DATA[15:0]}};
        end
        default: begin
          be_n    = 4'b1111;
          wdata_n = WRITE_DATA;
        end
      endcase
    end
  end

  // Stall must rise in the request cycle itself, before any register can capture the request.
  assign BUSYWAIT = !RESET &&
                    (((state == ST_IDLE) && req && !misaligned) || (state == ST_ACCESS));

  dmem_load_align u_load_align (
    .rdata  (mem.MEM_RDATA),
    .lane   (lane_q),
    .funct3 (f3_q),
    .data   (load_data)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= ST_IDLE;
      READ_DATA     <= 32'h0;
      MISALIGNED    <= 1'b0;
      BUS_ERROR     <= 1'b0;
      mem.MEM_REQ   <= 1'b0;
      mem.MEM_WE    <= 1'b0;
      mem.MEM_ADDR  <= 32'h0;
      mem.MEM_BE    <= 4'h0;
      mem.MEM_WDATA <= 32'h0;
      f3_q          <= 3'b000;
      lane_q        <= 2'b00;
      cnt           <= 16'h0;
    end else begin
      MISALIGNED <= 1'b0;
      BUS_ERROR  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (misaligned) begin
              MISALIGNED <= 1'b1;
              state      <= ST_DONE;
            end else begin
              mem.MEM_REQ   <= 1'b1;
              mem.MEM_WE    <= MEM_WRITE;
              mem.MEM_ADDR  <= {ADDRESS[31:2], 2'b00};
              mem.MEM_BE    <= be_n;
              mem.MEM_WDATA <= wdata_n;
              f3_q          <= FUNCT3;
              lane_q        <= ADDRESS[1:0];
              cnt           <= 16'h0;
              state         <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          // An ack arriving on the final allowed cycle still completes the access.
          if (mem.MEM_ACK) begin
            mem.MEM_REQ <= 1'b0;
            if (!mem.MEM_WE) READ_DATA <= load_data;
            state <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            mem.MEM_REQ <= 1'b0;
            BUS_ERROR   <= 1'b1;
            READ_DATA   <= 32'h0;
            state       <= ST_DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_busywait_ctrl.sv
// Directed bench for dmem_busywait_ctrl with an expected-READ_DATA scoreboard queue.
module tb_dmem_busywait_ctrl;
  import rv32_mem_pkg::*;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        busywait;
  logic        misaligned;
  logic        bus_error;

  int checks;
  int failures;
  logic [31:0] sb[$];

  dmem_busywait_ctrl_if bus ();

  dmem_busywait_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .CLK        (clk),
    .RESET      (reset),
    .MEM_READ   (mem_read),
    .MEM_WRITE  (mem_write),
    .FUNCT3     (funct3),
    .ADDRESS    (address),
    .WRITE_DATA (write_data),
    .READ_DATA  (read_data),
    .BUSYWAIT   (busywait),
    .MISALIGNED (misaligned),
    .BUS_ERROR  (bus_error),
    .mem        (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    funct3     = F3_W;
    address    = 32'h0;
    write_data = 32'h0;
  endtask

  // Full accepted access: request, ack after 'delay' extra ACCESS cycles, DONE, back to IDLE.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                            input int delay, input logic [31:0] rdata,
                            input logic [31:0] exp_read, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata);
    logic [31:0] exp_q;
    sb.push_back(exp_read);
    @(negedge clk);
    mem_read = rd; mem_write = wr; funct3 = f3; address = addr; write_data = wd;
    #1 check({tag, ".busy_req"}, 32'(busywait), 32'd1);
    @(negedge clk);
    check({tag, ".req"},   32'(bus.MEM_REQ), 32'd1);
    check({tag, ".we"},    32'(bus.MEM_WE), 32'(wr));
    check({tag, ".addr"},  bus.MEM_ADDR, {addr[31:2], 2'b00});
    check({tag, ".be"},    32'(bus.MEM_BE), 32'(exp_be));
    check({tag, ".wdata"}, bus.MEM_WDATA, exp_wdata);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check({tag, ".busy_wait"}, 32'(busywait), 32'd1);
      check({tag, ".req_hold"}, 32'(bus.MEM_REQ), 32'd1);
    end
    bus.MEM_ACK = 1'b1; bus.MEM_RDATA = rdata;
    @(negedge clk);
    bus.MEM_ACK = 1'b0; bus.MEM_RDATA = 32'h0;
    check({tag, ".busy_done"}, 32'(busywait), 32'd0);
    check({tag, ".req_done"}, 32'(bus.MEM_REQ), 32'd0);
    if (sb.size() == 0) begin
      checks++; failures++;
      $error("FAIL %s.sb observed=empty expected=entry", tag);
    end else begin
      exp_q = sb.pop_front();
      check({tag, ".read_data"}, read_data, exp_q);
    end
    idle_inputs();
    @(negedge clk);
    check({tag, ".idle_req"}, 32'(bus.MEM_REQ), 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    bus.MEM_ACK = 1'b0; bus.MEM_RDATA = 32'h0;
    idle_inputs();
    repeat (3) @(negedge clk);
    mem_read = 1'b1;
    #1;
    check("rst.busy", 32'(busywait), 32'd0);
    check("rst.read_data", read_data, 32'h0);
    check("rst.req", 32'(bus.MEM_REQ), 32'd0);
    check("rst.addr", bus.MEM_ADDR, 32'h0);
    check("rst.be", 32'(bus.MEM_BE), 32'd0);
    check("rst.flags", {30'd0, misaligned, bus_error}, 32'd0);
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;

    run_access("lw",   1, 0, F3_W,   32'h100, 0, 2, 32'h8badf00d, 32'h8badf00d, 4'hf, 0);
    run_access("lb",   1, 0, F3_B,   32'h103, 0, 0, 32'h80aabbcc, 32'hffffff80, 4'hf, 0);
    run_access("lbu",  1, 0, F3_BU,  32'h103, 0, 1, 32'h80aabbcc, 32'h00000080, 4'hf, 0);
    run_access("lhu",  1, 0, F3_HU,  32'h102, 0, 0, 32'h80aabbcc, 32'h000080aa, 4'hf, 0);
    run_access("lh",   1, 0, F3_H,   32'h100, 0, 0, 32'h80aabbcc, 32'hffffbbcc, 4'hf, 0);
    run_access("lw011",1, 0, 3'b011, 32'h104, 0, 3, 32'h12345678, 32'h12345678, 4'hf, 0);
    run_access("sb",   0, 1, F3_B,   32'h201, 32'h000000a5, 0, 0, 32'h12345678, 4'b0010, 32'ha5a5a5a5);
    run_access("sh",   0, 1, F3_H,   32'h202, 32'h00001234, 1, 0, 32'h12345678, 4'b1100, 32'h12341234);
    run_access("rw_sw",1, 1, F3_W,   32'h300, 32'hdeadbeef, 0, 0, 32'h12345678, 4'b1111, 32'hdeadbeef);

    // Misaligned word load: rejected without a transaction.
    @(negedge clk);
    mem_read = 1'b1; funct3 = F3_W; address = 32'h102;
    #1 check("mis.busy_req", 32'(busywait), 32'd0);
    @(negedge clk);
    check("mis.pulse", 32'(misaligned), 32'd1);
    check("mis.req", 32'(bus.MEM_REQ), 32'd0);
    check("mis.busy_done", 32'(busywait), 32'd0);
    check("mis.read_data", read_data, 32'h12345678);
    idle_inputs();
    @(negedge clk);
    check("mis.pulse_end", 32'(misaligned), 32'd0);

    // Timeout: no ack for 4 ACCESS cycles.
    @(negedge clk);
    mem_read = 1'b1; funct3 = F3_W; address = 32'h400;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("to.req_hold", 32'(bus.MEM_REQ), 32'd1);
      check("to.no_err", 32'(bus_error), 32'd0);
    end
    @(negedge clk);
    check("to.bus_error", 32'(bus_error), 32'd1);
    check("to.req_drop", 32'(bus.MEM_REQ), 32'd0);
    check("to.read_data", read_data, 32'h0);
    check("to.busy_done", 32'(busywait), 32'd0);
    idle_inputs();
    @(negedge clk);
    check("to.err_end", 32'(bus_error), 32'd0);

    // Stray ack in IDLE must not touch READ_DATA.
    run_access("lw2", 1, 0, F3_W, 32'h500, 0, 0, 32'hcafef00d, 32'hcafef00d, 4'hf, 0);
    bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'h11111111;
    @(negedge clk);
    bus.MEM_ACK = 1'b0;
    check("idle_ack.read_data", read_data, 32'hcafef00d);

    // Reset in the middle of an access.
    mem_read = 1'b1; funct3 = F3_W; address = 32'h600;
    @(negedge clk);
    check("rmid.req", 32'(bus.MEM_REQ), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rmid.req_drop", 32'(bus.MEM_REQ), 32'd0);
    check("rmid.busy", 32'(busywait), 32'd0);
    check("rmid.read_data", read_data, 32'h0);
    check("rmid.addr", bus.MEM_ADDR, 32'h0);
    idle_inputs();
    reset = 1'b0;
    bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'h22222222;
    @(negedge clk);
    bus.MEM_ACK = 1'b0;
    @(negedge clk);
    check("rmid.late_ack", read_data, 32'h0);
    check("rmid.late_req", 32'(bus.MEM_REQ), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
